// File: rtl/wb_dma_pkg.sv
// Shared definitions for the Wishbone DMA master.
//   dma_state_t : FSM state encoding
//   SEL_ALL     : byte-select value driven while a phase is active
//   ADDR_STEP   : byte increment between consecutive 32-bit words
package wb_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_FINISH,
        ST_FAULT
    } dma_state_t;

    localparam logic [3:0] SEL_ALL   = 4'hF;
    localparam int         ADDR_STEP = 4;

endpackage

// File: rtl/wb_dma_master_if.sv
// Wishbone master bus bundle for wb_dma_master.
//   master modport : cyc/stb/we/sel/adr/dat_o driven, dat_i/ack/err sampled
//   slave modport  : the mirror image, for a memory or bus model
interface wb_dma_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  m_wb_cyc_o;
    logic                  m_wb_stb_o;
    logic                  m_wb_we_o;
    logic [3:0]            m_wb_sel_o;
    logic [ADDR_WIDTH-1:0] m_wb_adr_o;
    logic [31:0]           m_wb_dat_o;
    logic [31:0]           m_wb_dat_i;
    logic                  m_wb_ack_i;
    logic                  m_wb_err_i;

    modport master (
        output m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o, m_wb_adr_o, m_wb_dat_o,
        input  m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );

    modport slave (
        input  m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o, m_wb_adr_o, m_wb_dat_o,
        output m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );
endinterface

// File: rtl/wb_dma_watchdog.sv
// Per-phase ack timeout for wb_dma_master (only built with WB_DMA_TIMEOUT_EN).
//   clk, rst_n : clock, async active-low reset
//   restart    : a new bus phase starts this cycle; reload the down-counter
//   active     : a bus phase is currently outstanding
//   expired    : CYCLES stb-high cycles have elapsed without a response
module wb_dma_watchdog #(
    parameter int CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic active,
    output logic expired
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt;

    // Loaded with CYCLES-1 so that the terminal count is reached during the
    // CYCLES-th cycle of the phase, letting the FSM abort on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= CW'(CYCLES - 1);
        end else if (active && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = active && (cnt == '0);
endmodule

// File: rtl/wb_dma_master.sv
// Wishbone memory-to-memory copy engine (word granularity).
//   clk, rst_n          : clock, async active-low reset
//   start               : one-cycle copy request, honoured only when idle
//   src_addr, dst_addr  : word-aligned byte addresses
//   len                 : number of 32-bit words to copy
//   busy, done, error   : status (done is a one-cycle pulse, error is sticky)
//   words_done          : words written in the current/last copy
//   irq                 : done_seen | error, cleared by an accepted start
//   wb                  : Wishbone master bus (wb_dma_master_if.master)
// Build option: define WB_DMA_TIMEOUT_EN to abort a phase that receives no
// ack/err within TIMEOUT_CYCLES cycles (treated exactly like err_i).
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | waiting for start
// ST_READ   | read phase on the bus, waiting for ack/err
// ST_WRITE  | write phase on the bus, waiting for ack/err
// ST_FINISH | bus released, done pulse being issued
// ST_FAULT  | bus released after err/timeout, back to idle
module wb_dma_master
    import wb_dma_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  words_done,
    output logic                  irq,
    wb_dma_master_if.master       wb
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

    dma_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, adr_q, adr_d;
    logic [LEN_WIDTH-1:0]  left_q, left_d, wdone_q, wdone_d;
    logic [31:0]           dat_q, dat_d;
    logic [3:0]            sel_q, sel_d;
    logic                  cyc_q, cyc_d, we_q, we_d;
    logic                  done_q, done_d, error_q, error_d, irq_q, irq_d;
    logic                  timeout;

`ifdef WB_DMA_TIMEOUT_EN
    logic phase_restart;
    logic phase_active;

    assign phase_active  = (state == ST_READ) || (state == ST_WRITE);
    assign phase_restart = (state_nxt != state) &&
                           ((state_nxt == ST_READ) || (state_nxt == ST_WRITE));

    wb_dma_watchdog #(.CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (phase_restart),
        .active  (phase_active),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            adr_q   <= '0;
            left_q  <= '0;
            wdone_q <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            src_q   <= src_d;
            dst_q   <= dst_d;
            adr_q   <= adr_d;
            left_q  <= left_d;
            wdone_q <= wdone_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            done_q  <= done_d;
            error_q <= error_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_nxt = state;
        src_d     = src_q;
        dst_d     = dst_q;
        adr_d     = adr_q;
        left_d    = left_q;
        wdone_d   = wdone_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        done_d    = 1'b0;
        error_d   = error_q;
        irq_d     = irq_q;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    wdone_d = '0;
                    irq_d   = 1'b0;
                    if (len != '0) begin
                        src_d     = src_addr;
                        dst_d     = dst_addr;
                        left_d    = len;
                        cyc_d     = 1'b1;
                        sel_d     = SEL_ALL;
                        we_d      = 1'b0;
                        adr_d     = src_addr;
                        state_nxt = ST_READ;
                    end else begin
                        state_nxt = ST_FINISH;
                    end
                end
            end
            ST_READ, ST_WRITE: begin
                // err (or a timeout) takes priority over a simultaneous ack
                if (wb.m_wb_err_i || timeout) begin
                    cyc_d     = 1'b0;
                    sel_d     = '0;
                    we_d      = 1'b0;
                    error_d   = 1'b1;
                    irq_d     = 1'b1;
                    state_nxt = ST_FAULT;
                end else if (wb.m_wb_ack_i && state == ST_READ) begin
                    dat_d     = wb.m_wb_dat_i;
                    we_d      = 1'b1;
                    adr_d     = dst_q;
                    state_nxt = ST_WRITE;
                end else if (wb.m_wb_ack_i) begin
                    wdone_d = wdone_q + LEN_WIDTH'(1);
                    src_d   = src_q + STEP;
                    dst_d   = dst_q + STEP;
                    we_d    = 1'b0;
                    if (left_q == LEN_WIDTH'(1)) begin
                        cyc_d     = 1'b0;
                        sel_d     = '0;
                        state_nxt = ST_FINISH;
                    end else begin
                        left_d    = left_q - LEN_WIDTH'(1);
                        adr_d     = src_q + STEP;
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_FINISH: begin
                done_d    = 1'b1;
                irq_d     = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign wb.m_wb_cyc_o = cyc_q;
    assign wb.m_wb_stb_o = cyc_q;
    assign wb.m_wb_we_o  = we_q;
    assign wb.m_wb_sel_o = sel_q;
    assign wb.m_wb_adr_o = adr_q;
    assign wb.m_wb_dat_o = dat_q;

    assign busy       = (state == ST_READ) || (state == ST_WRITE) || (state == ST_FINISH);
    assign done       = done_q;
    assign error      = error_q;
    assign irq        = irq_q;
    assign words_done = wdone_q;
endmodule

// File: tb/tb_wb_dma_master.sv
module tb_wb_dma_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, error, irq;
    logic [15:0] words_done;

    wb_dma_master_if #(.ADDR_WIDTH(32)) bus ();

    always #5 clk = ~clk;

    wb_dma_master #(
        .ADDR_WIDTH     (32),
        .LEN_WIDTH      (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done),
        .irq        (irq),
        .wb         (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xact_t;

    xact_t       xlog[$];
    logic [31:0] salt;

    // Source memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    int max_wait    = 0;
    bit never_ack   = 0;
    int err_write_n = 0;
    int writes_seen = 0;
    int done_cnt    = 0;
    int cyc_cycles  = 0;
    int sel_bad     = 0;
    int wait_left   = 0;
    bit new_phase   = 1;
    bit err_follow  = 0;

    // Slave model and monitor; responses are set up half a cycle before the
    // edge on which the DUT samples them.
    always @(negedge clk) begin
        bit resp;
        resp = 0;
        if (err_follow) begin
            check_val("err_cyc_drop", bus.m_wb_cyc_o, 0);
            err_follow = 0;
        end
        if (done) done_cnt++;
        if (bus.m_wb_cyc_o) cyc_cycles++;
        if (bus.m_wb_stb_o !== bus.m_wb_cyc_o ||
            bus.m_wb_sel_o !== (bus.m_wb_stb_o ? 4'hF : 4'h0)) sel_bad++;
        bus.m_wb_ack_i = 1'b0;
        bus.m_wb_err_i = 1'b0;
        if (rst_n && bus.m_wb_cyc_o && bus.m_wb_stb_o) begin
            if (new_phase) begin
                wait_left = int'($urandom_range(max_wait));
                new_phase = 0;
            end
            if (!never_ack) begin
                if (wait_left > 0) wait_left--;
                else resp = 1;
            end
            if (resp) begin
                new_phase = 1;
                bus.m_wb_ack_i = 1'b1;
                if (bus.m_wb_we_o) begin
                    writes_seen++;
                    if (writes_seen == err_write_n) begin
                        bus.m_wb_err_i = 1'b1;
                        err_follow = 1;
                    end else begin
                        xlog.push_back('{1'b1, bus.m_wb_adr_o, bus.m_wb_dat_o});
                    end
                end else begin
                    bus.m_wb_dat_i = mem_word(bus.m_wb_adr_o);
                    xlog.push_back('{1'b0, bus.m_wb_adr_o, mem_word(bus.m_wb_adr_o)});
                end
            end
        end else begin
            new_phase = 1;
        end
    end

    task automatic clear_mon();
        xlog.delete();
        done_cnt    = 0;
        cyc_cycles  = 0;
        sel_bad     = 0;
        writes_seen = 0;
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(posedge clk); #1;
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && error !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) check_val({tag, "_budget"}, 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_copy(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
        check_val({tag, "_nx"}, xlog.size(), 2 * n);
        for (int i = 0; i < n; i++) begin
            if (2 * i + 1 < xlog.size()) begin
                check_val({tag, "_rd_adr"}, {xlog[2*i].we, xlog[2*i].adr}, {1'b0, s + 32'(4 * i)});
                check_val({tag, "_rd_dat"}, xlog[2*i].dat, mem_word(s + 32'(4 * i)));
                check_val({tag, "_wr_adr"}, {xlog[2*i+1].we, xlog[2*i+1].adr}, {1'b1, d + 32'(4 * i)});
                check_val({tag, "_wr_dat"}, xlog[2*i+1].dat, mem_word(s + 32'(4 * i)));
            end
        end
        check_val({tag, "_done_cnt"}, done_cnt, 1);
        check_val({tag, "_words"}, words_done, n);
        check_val({tag, "_err"}, error, 0);
        check_val({tag, "_irq"}, irq, 1);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_cyc"}, bus.m_wb_cyc_o, 0);
        check_val({tag, "_sel"}, sel_bad, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, {busy, done, error, irq}, 4'b0);
        check_val({tag, "_words"}, words_done, 0);
        check_val({tag, "_bus"}, {bus.m_wb_cyc_o, bus.m_wb_stb_o, bus.m_wb_we_o, bus.m_wb_sel_o}, 7'b0);
        check_val({tag, "_adr_dat"}, {bus.m_wb_adr_o, bus.m_wb_dat_o}, 64'b0);
    endtask

    initial begin
        logic [31:0] s;
        int          n;
        int          k;

        salt = $urandom;
        bus.m_wb_ack_i = 1'b0;
        bus.m_wb_err_i = 1'b0;
        bus.m_wb_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed copy, zero-wait slave
        clear_mon();
        max_wait = 0;
        pulse_start(32'h0001_0000, 32'h0002_0000, 16'd3);
        wait_idle("basic");
        check_copy("basic", 32'h0001_0000, 32'h0002_0000, 3);
        check_val("basic_cyc_cycles", cyc_cycles, 6);

        // Zero-length copy
        clear_mon();
        pulse_start(32'h0000_1000, 32'h0000_2000, 16'd0);
        check_val("len0_busy", busy, 1);
        check_val("len0_done_early", done, 0);
        @(posedge clk); #1;
        check_val("len0_done", done, 1);
        check_val("len0_irq", irq, 1);
        @(posedge clk); #1;
        check_val("len0_done_once", done, 0);
        check_val("len0_err", error, 0);
        check_val("len0_cyc_cycles", cyc_cycles, 0);

        // err_i together with ack_i on the second write
        clear_mon();
        err_write_n = 2;
        pulse_start(32'h0000_3000, 32'h0000_4000, 16'd4);
        wait_idle("errw");
        err_write_n = 0;
        check_val("errw_err", error, 1);
        check_val("errw_words", words_done, 1);
        check_val("errw_done_cnt", done_cnt, 0);
        check_val("errw_irq", irq, 1);
        check_val("errw_busy", busy, 0);
        check_val("errw_nx", xlog.size(), 3);

        // Destination wrap, plus a start pulse while busy that must be ignored
        clear_mon();
        max_wait = 2;
        pulse_start(32'h0000_5000, 32'hFFFF_FFFC, 16'd2);
        check_val("wrap_busy", busy, 1);
        pulse_start(32'h0000_7000, 32'h0000_8000, 16'd5);
        wait_idle("wrap");
        check_copy("wrap", 32'h0000_5000, 32'hFFFF_FFFC, 2);

        // Asynchronous reset during the write of word 2
        clear_mon();
        max_wait = 3;
        pulse_start(32'h0000_8000, 32'h0000_9000, 16'd3);
        k = 0;
        while (!(words_done == 16'd1 && bus.m_wb_we_o === 1'b1) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 500) check_val("rst_mid_budget", 0, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        max_wait = 0;
        pulse_start(32'h0000_A000, 32'h0000_B000, 16'd1);
        wait_idle("after_rst");
        check_copy("after_rst", 32'h0000_A000, 32'h0000_B000, 1);

        // Randomized copies with random wait states
        for (int t = 0; t < 15; t++) begin
            clear_mon();
            max_wait = int'($urandom_range(3));
            s = $urandom & 32'h0FFF_FFFC;
            n = int'($urandom_range(1, 6));
            pulse_start(s, s ^ 32'h8000_0000, 16'(n));
            wait_idle("rand");
            check_copy("rand", s, s ^ 32'h8000_0000, n);
        end

        // Slave that never answers
        clear_mon();
        never_ack = 1;
        pulse_start(32'h0000_C000, 32'h0000_D000, 16'd1);
`ifdef WB_DMA_TIMEOUT_EN
        k = 0;
        while (bus.m_wb_cyc_o === 1'b1 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) check_val("tmo_budget", 0, 1);
        check_val("tmo_stb_cycles", cyc_cycles, 8);
        check_val("tmo_err", error, 1);
        check_val("tmo_irq", irq, 1);
        repeat (2) @(posedge clk);
        #1;
        check_val("tmo_done_cnt", done_cnt, 0);
        check_val("tmo_busy", busy, 0);
`else
        repeat (100) @(posedge clk);
        #1;
        check_val("hang_cyc_stb", {bus.m_wb_cyc_o, bus.m_wb_stb_o}, 2'b11);
        check_val("hang_err", error, 0);
        check_val("hang_busy", busy, 1);
`endif
        never_ack = 0;
        rst_n = 1'b0;
        #1 check_all_zero("final_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_dma_master.md
WB_DMA_MASTER -- requirements
Module: wb_dma_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: Wishbone byte-address width.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: word-count width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: ack wait limit per bus phase.
REQ-004 SHALL use one clock and an asynchronous, active-low reset:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
REQ-005 SHALL have the following control ports:
- start  input  1  one-cycle request to begin a copy
- src_addr  input  ADDR_WIDTH  source byte address, word-aligned
- dst_addr  input  ADDR_WIDTH  destination byte address, word-aligned
- len  input  LEN_WIDTH  number of 32-bit words to copy
- busy  output  1  copy in progress
- done  output  1  one-cycle pulse on successful completion
- error  output  1  sticky bus-error/timeout flag
- words_done  output  LEN_WIDTH  words fully written in the current or last copy
- irq  output  1  level, equals done_seen OR error, cleared by start
REQ-006 SHALL have the following Wishbone master ports:
- m_wb_cyc_o, m_wb_stb_o, m_wb_we_o  output  1 each
- m_wb_sel_o  output  4
- m_wb_adr_o  output  ADDR_WIDTH
- m_wb_dat_o  output  32
- m_wb_dat_i  input  32
- m_wb_ack_i, m_wb_err_i  input  1 each

Function
REQ-007 SHALL implement FSM states IDLE, READ, WRITE, FINISH, FAULT; all Wishbone outputs registered.
REQ-008 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-009 On start with len>0, the FSM SHALL latch src/dst/len, clear error, words_done and irq, and enter READ; cyc=stb=1, we=0, adr=src are asserted in the next cycle.
REQ-010 On start with len==0, the FSM SHALL enter FINISH with no bus activity; done pulses the next cycle.
REQ-011 In READ, on ack_i without err_i, the FSM SHALL capture dat_i and enter WRITE; WRITE asserts we=1, adr=dst, dat_o=captured word in the next cycle.
REQ-012 In WRITE, on ack_i without err_i, the FSM SHALL increment words_done, advance src and dst by 4 (modulo 2^ADDR_WIDTH), and go to READ if words remain, else FINISH.
REQ-013 cyc and stb SHALL stay high continuously across READ/WRITE phases (back-to-back); the minimum is 2 cycles per word with zero-wait-state slaves.
REQ-014 m_wb_sel_o SHALL be 4'hF whenever stb=1, and 0 otherwise.
REQ-015 FINISH SHALL drop cyc/stb/we, pulse done for exactly one cycle, set irq, and return to IDLE.
REQ-016 err_i in READ or WRITE SHALL win over a simultaneous ack_i: the FSM enters FAULT, drops cyc/stb next cycle, sets error and irq, words_done is not incremented, and the FSM returns to IDLE without a done pulse.
REQ-017 busy SHALL be 1 in READ, WRITE and FINISH, and 0 in IDLE and FAULT.

Reset
REQ-018 Asserting rst_n low at any time, including mid-transfer, SHALL immediately force IDLE and drive cyc, stb, we, sel, adr, dat_o, busy, done, error, irq and words_done to 0.

Configuration
REQ-019 With WB_DMA_TIMEOUT_EN defined:
- a counter restarts at each new READ/WRITE phase;
- if TIMEOUT_CYCLES cycles elapse without ack_i or err_i, the block SHALL behave exactly as on err_i (REQ-016).
REQ-020 Without WB_DMA_TIMEOUT_EN, the block SHALL wait indefinitely for ack_i/err_i, and no counter logic is present.

Structure
REQ-021 A shared package wb_dma_pkg SHALL hold the FSM state enum, the SEL_ALL=4'hF constant, and the ADDR_STEP=4 constant.
REQ-022 The timeout counter SHALL be a separate sub-module wb_dma_watchdog, instantiated only under WB_DMA_TIMEOUT_EN.

Verification
REQ-023 src=0x0001_0000, dst=0x0002_0000, len=3, zero-wait slave -> 6 acked phases:
- reads at 0x10000, 0x10004, 0x10008; writes at 0x20000, 0x20004, 0x20008 with matching data;
- done pulses once; words_done=3; cyc drops after the 6th ack.
REQ-024 len=0 start -> no cyc assertion; done pulses 2 cycles after start; irq=1, error=0.
REQ-025 err_i asserted together with ack_i on the 2nd write of a len=4 copy -> error=1, words_done=1, no done pulse, cyc low the next cycle.
REQ-026 WB_DMA_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> cyc drops and error=1 after 8 stb-high cycles; without the macro, cyc stays high for 100 cycles.
REQ-027 rst_n pulsed low during the WRITE phase of word 2 -> all outputs 0 asynchronously; a subsequent start with len=1 completes normally.
REQ-028 dst=0xFFFF_FFFC, len=2 -> 2nd write address wraps to 0x0000_0000; start pulsed while busy is ignored.
